// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// decode_queue : RV32I(+M) single-issue decoder feeding a DEPTH-entry micro-op
//                FIFO with valid/ready handshakes and a one-cycle flush.
// Revision     : 1.0
// ============================================================================
module decode_queue #(
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                instr,
  input  logic [31:0]                pc_in,
  input  logic [31:0]                next_pc_in,
  output logic [4:0]                 rs1_select,
  output logic [4:0]                 rs2_select,
  input  logic [31:0]                rs1_data,
  input  logic [31:0]                rs2_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                pc_out,
  output logic [31:0]                next_pc_out,
  output logic [31:0]                data_rs1,
  output logic [31:0]                data_rs2,
  output logic [31:0]                data_imm,
  output logic [4:0]                 rs1_addr,
  output logic [4:0]                 rs2_addr,
  output logic [4:0]                 rd_addr,
  output logic [11:0]                csr_addr,
  output logic [2:0]                 alu_func,
  output logic                       alu_func_sel,
  output logic [1:0]                 alu_a_select,
  output logic [1:0]                 alu_b_select,
  output logic [1:0]                 write_select,
  output logic [1:0]                 load_store_size,
  output logic                       jump,
  output logic                       branch,
  output logic                       load,
  output logic                       load_signed,
  output logic                       store,
  output logic                       read_csr,
  output logic                       write_csr,
  output logic                       mul_div,
  output logic                       exception,
  output logic                       cmp_less,
  output logic                       cmp_sign,
  output logic                       cmp_negate,
  output logic [3:0]                 ecause,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  // Operand/writeback select encodings shared with the execute stage.
  localparam logic [1:0] c_A_REG = 2'd0, c_A_PC  = 2'd1, c_A_IMM = 2'd2, c_A_ZERO = 2'd3;
  localparam logic [1:0] c_B_REG = 2'd0, c_B_IMM = 2'd1, c_B_CSR = 2'd2, c_B_ZERO = 2'd3;
  localparam logic [1:0] c_W_ALU = 2'd0, c_W_LOAD = 2'd1, c_W_NPC = 2'd2, c_W_CSR = 2'd3;
  localparam logic [2:0] c_F_ADD = 3'b000, c_F_OR = 3'b110, c_F_ANDC = 3'b111;

  typedef struct packed {
    logic [31:0] pc, npc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [2:0]  func;
    logic        fsel;
    logic [1:0]  asel, bsel, wsel, size;
    logic        jump, branch, load, lsigned, store, rcsr, wcsr, muldiv, exc;
    logic        cless, csign, cneg;
    logic [3:0]  ecause;
  } uop_t;

  logic [6:0]  w_opcode, w_f7;
  logic [2:0]  w_f3;
  logic        w_illegal, w_push, w_pop;
  uop_t        w_uop, w_head;
  uop_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;

  assign w_opcode   = instr[6:0];
  assign w_f3       = instr[14:12];
  assign w_f7       = instr[31:25];
  assign rs1_select = instr[19:15];
  assign rs2_select = instr[24:20];

  always_comb begin
    w_uop     = '0;
    w_illegal = 1'b0;
    w_uop.pc  = pc_in;
    w_uop.npc = next_pc_in;
    w_uop.d1  = rs1_data;
    w_uop.d2  = rs2_data;
    w_uop.rs1 = instr[19:15];
    w_uop.rs2 = instr[24:20];
    w_uop.rd  = instr[11:7];
    w_uop.csr = instr[31:20];
    case (w_opcode)
      7'b0110111, 7'b0010111: w_uop.imm = {instr[31:12], 12'b0};
      7'b1101111: w_uop.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      7'b1100111, 7'b0000011, 7'b0010011: w_uop.imm = {{20{instr[31]}}, instr[31:20]};
      7'b0100011: w_uop.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      7'b1100011: w_uop.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      default:    w_uop.imm = '0;
    endcase
    case (w_opcode)
      7'b0110111: begin
        w_uop.func = c_F_OR;  w_uop.asel = c_A_ZERO; w_uop.bsel = c_B_IMM;
      end
      7'b0010111: begin
        w_uop.func = c_F_ADD; w_uop.asel = c_A_PC;   w_uop.bsel = c_B_IMM;
      end
      7'b1101111, 7'b1100111: begin
        w_uop.func   = c_F_ADD;
        w_uop.asel   = (w_opcode == 7'b1101111) ? c_A_PC : c_A_REG;
        w_uop.bsel   = c_B_IMM;
        w_uop.wsel   = c_W_NPC;
        w_uop.branch = 1'b1;
        w_uop.jump   = 1'b1;
        w_illegal    = (w_opcode == 7'b1100111) && (w_f3 != 3'b000);
      end
      7'b1100011: begin
        w_uop.func   = c_F_ADD; w_uop.asel = c_A_PC; w_uop.bsel = c_B_IMM;
        w_uop.branch = 1'b1;
        w_uop.rd     = '0;
        w_uop.cless  = instr[14];
        w_uop.csign  = instr[13];
        w_uop.cneg   = instr[12];
        w_illegal    = (w_f3[2:1] == 2'b01);
      end
      7'b0000011: begin
        w_uop.func    = c_F_ADD; w_uop.asel = c_A_REG; w_uop.bsel = c_B_IMM;
        w_uop.wsel    = c_W_LOAD;
        w_uop.load    = 1'b1;
        w_uop.size    = instr[13:12];
        w_uop.lsigned = !instr[14];
        w_illegal     = (instr[13:12] == 2'b11) || (instr[14] && instr[13:12] == 2'b10);
      end
      7'b0100011: begin
        w_uop.func  = c_F_ADD; w_uop.asel = c_A_REG; w_uop.bsel = c_B_IMM;
        w_uop.store = 1'b1;
        w_uop.rd    = '0;
        w_uop.size  = instr[13:12];
        w_illegal   = (instr[13:12] == 2'b11) || instr[14];
      end
      7'b0010011: begin
        w_uop.func = w_f3; w_uop.asel = c_A_REG; w_uop.bsel = c_B_IMM;
        w_uop.fsel = (w_f3 == 3'b101) && instr[30];
        w_illegal  = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                     ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
      end
      7'b0110011: begin
        w_uop.func = w_f3; w_uop.fsel = instr[30];
        w_uop.asel = c_A_REG; w_uop.bsel = c_B_REG;
        case (w_f7)
          7'b0000000: w_illegal = 1'b0;
          7'b0100000: w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
          7'b0000001: begin
            w_illegal    = !ENABLE_M;
            w_uop.muldiv = ENABLE_M;
          end
          default:    w_illegal = 1'b1;
        endcase
      end
      7'b0001111: begin
        w_uop.rd  = '0;
        w_illegal = (w_f3 != 3'b000);
      end
      7'b1110011: begin
        if (w_f3 == 3'b000) begin
          w_uop.exc    = 1'b1;
          w_uop.rd     = '0;
          w_uop.ecause = ((|instr[31:21]) || (|instr[19:7])) ? 4'd2 :
                         (instr[20] ? 4'd3 : 4'd11);
        end else if (w_f3 == 3'b100) begin
          w_illegal = 1'b1;
        end else begin
          // rd receives the old CSR value; the ALU forms the new one.
          w_uop.asel = w_f3[2] ? c_A_IMM : c_A_REG;
          w_uop.wsel = c_W_CSR;
          w_uop.func = c_F_OR;
          w_uop.rcsr = 1'b1;
          w_uop.wcsr = (instr[19:15] != 5'd0);
          case (w_f3[1:0])
            2'b01: begin
              w_uop.bsel = c_B_ZERO;
              w_uop.rcsr = (instr[11:7] != 5'd0);
              w_uop.wcsr = 1'b1;
            end
            2'b10:   w_uop.bsel = c_B_CSR;
            default: begin
              w_uop.bsel = c_B_CSR;
              w_uop.func = c_F_ANDC;
              w_uop.fsel = 1'b1;
            end
          endcase
        end
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_uop.exc    = 1'b1;
      w_uop.ecause = 4'd2;
      w_uop.rd     = '0;
      w_uop.load   = 1'b0;
      w_uop.store  = 1'b0;
      w_uop.branch = 1'b0;
      w_uop.jump   = 1'b0;
      w_uop.wcsr   = 1'b0;
      w_uop.rcsr   = 1'b0;
      w_uop.muldiv = 1'b0;
    end
  end

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (r_count != '0);
  assign in_ready  = (r_count < CW'(DEPTH)) || out_ready;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_uop;
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign count           = r_count;
  assign pc_out          = w_head.pc;
  assign next_pc_out     = w_head.npc;
  assign data_rs1        = w_head.d1;
  assign data_rs2        = w_head.d2;
  assign data_imm        = w_head.imm;
  assign rs1_addr        = w_head.rs1;
  assign rs2_addr        = w_head.rs2;
  assign rd_addr         = w_head.rd;
  assign csr_addr        = w_head.csr;
  assign alu_func        = w_head.func;
  assign alu_func_sel    = w_head.fsel;
  assign alu_a_select    = w_head.asel;
  assign alu_b_select    = w_head.bsel;
  assign write_select    = w_head.wsel;
  assign load_store_size = w_head.size;
  assign jump            = w_head.jump;
  assign branch          = w_head.branch;
  assign load            = w_head.load;
  assign load_signed     = w_head.lsigned;
  assign store           = w_head.store;
  assign read_csr        = w_head.rcsr;
  assign write_csr       = w_head.wcsr;
  assign mul_div         = w_head.muldiv;
  assign exception       = w_head.exc;
  assign cmp_less        = w_head.cless;
  assign cmp_sign        = w_head.csign;
  assign cmp_negate      = w_head.cneg;
  assign ecause          = w_head.ecause;
endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// tb_decode_queue : directed and randomized bench for decode_queue, DEPTH=2,
//                   one instance per ENABLE_M setting driven by shared inputs.
// Revision        : 1.0
// ============================================================================
module tb_decode_queue;
  localparam int DEPTH = 2;
  localparam logic [1:0] A_REG = 2'd0, A_PC = 2'd1, A_IMM = 2'd2, A_ZERO = 2'd3;
  localparam logic [1:0] B_REG = 2'd0, B_IMM = 2'd1, B_CSR = 2'd2, B_ZERO = 2'd3;
  localparam logic [1:0] W_ALU = 2'd0, W_LOAD = 2'd1, W_NPC = 2'd2, W_CSR = 2'd3;
  localparam logic [2:0] F_ADD = 3'b000, F_OR = 3'b110, F_ANDC = 3'b111;

  typedef struct packed {
    logic [31:0] pc, npc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [2:0]  func;
    logic        fsel;
    logic [1:0]  asel, bsel, wsel, size;
    logic        jump, branch, load, lsigned, store, rcsr, wcsr, muldiv, exc;
    logic        cless, csign, cneg;
    logic [3:0]  ecause;
  } uop_t;

  typedef struct packed {
    uop_t       u;
    logic       ov, ir;
    logic [1:0] cnt;
    logic [4:0] s1, s2;
  } out_t;

  typedef struct packed {
    logic [31:0] instr, pc, npc, r1, r2;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] instr, pc_in, next_pc_in, rs1_data, rs2_data;
  wire out_t   w_out [2];
  entry_t      q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_dut
      decode_queue #(.DEPTH(DEPTH), .ENABLE_M(k == 1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_out[k].ir),
        .instr(instr), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .rs1_select(w_out[k].s1), .rs2_select(w_out[k].s2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(w_out[k].ov), .out_ready(out_ready),
        .pc_out(w_out[k].u.pc), .next_pc_out(w_out[k].u.npc),
        .data_rs1(w_out[k].u.d1), .data_rs2(w_out[k].u.d2), .data_imm(w_out[k].u.imm),
        .rs1_addr(w_out[k].u.rs1), .rs2_addr(w_out[k].u.rs2), .rd_addr(w_out[k].u.rd),
        .csr_addr(w_out[k].u.csr), .alu_func(w_out[k].u.func), .alu_func_sel(w_out[k].u.fsel),
        .alu_a_select(w_out[k].u.asel), .alu_b_select(w_out[k].u.bsel),
        .write_select(w_out[k].u.wsel), .load_store_size(w_out[k].u.size),
        .jump(w_out[k].u.jump), .branch(w_out[k].u.branch), .load(w_out[k].u.load),
        .load_signed(w_out[k].u.lsigned), .store(w_out[k].u.store),
        .read_csr(w_out[k].u.rcsr), .write_csr(w_out[k].u.wcsr),
        .mul_div(w_out[k].u.muldiv), .exception(w_out[k].u.exc),
        .cmp_less(w_out[k].u.cless), .cmp_sign(w_out[k].u.csign),
        .cmp_negate(w_out[k].u.cneg), .ecause(w_out[k].u.ecause), .count(w_out[k].cnt)
      );
    end
  endgenerate

  // Reference decode, built from the instruction-set rules with plain arithmetic.
  function automatic uop_t ref_decode(input entry_t e, input bit en_m);
    uop_t u;
    logic [31:0] i;
    int f3, f7;
    bit bad;
    u = '0; i = e.instr; bad = 1'b0;
    f3 = int'(i[14:12]); f7 = int'(i[31:25]);
    u.pc = e.pc; u.npc = e.npc; u.d1 = e.r1; u.d2 = e.r2;
    u.rs1 = i[19:15]; u.rs2 = i[24:20]; u.rd = i[11:7]; u.csr = i[31:20];
    case (i[6:0])
      7'b0110111: begin u.imm = i & 32'hFFFFF000; u.func = F_OR; u.asel = A_ZERO; u.bsel = B_IMM; end
      7'b0010111: begin u.imm = i & 32'hFFFFF000; u.func = F_ADD; u.asel = A_PC; u.bsel = B_IMM; end
      7'b1101111, 7'b1100111: begin
        if (i[3]) u.imm = (i[31] ? 32'hFFF00000 : 32'h0) + 32'(i[19:12]) * 4096 +
                          32'(i[20]) * 2048 + 32'(i[30:21]) * 2;
        else      u.imm = 32'($signed(i) >>> 20);
        u.func = F_ADD; u.asel = i[3] ? A_PC : A_REG; u.bsel = B_IMM; u.wsel = W_NPC;
        u.branch = 1'b1; u.jump = 1'b1;
        bad = !i[3] && (f3 != 0);
      end
      7'b1100011: begin
        u.imm = (i[31] ? 32'hFFFFF000 : 32'h0) + 32'(i[7]) * 2048 +
                32'(i[30:25]) * 32 + 32'(i[11:8]) * 2;
        u.func = F_ADD; u.asel = A_PC; u.bsel = B_IMM; u.branch = 1'b1; u.rd = '0;
        u.cless = (f3 >= 4); u.csign = (f3 % 4 >= 2); u.cneg = (f3 % 2 == 1);
        bad = (f3 == 2) || (f3 == 3);
      end
      7'b0000011: begin
        u.imm = 32'($signed(i) >>> 20);
        u.func = F_ADD; u.asel = A_REG; u.bsel = B_IMM; u.wsel = W_LOAD; u.load = 1'b1;
        u.size = i[13:12]; u.lsigned = (f3 < 4);
        bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'b0100011: begin
        u.imm = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        u.func = F_ADD; u.asel = A_REG; u.bsel = B_IMM; u.store = 1'b1; u.rd = '0;
        u.size = i[13:12];
        bad = (f3 > 2);
      end
      7'b0010011: begin
        u.imm = 32'($signed(i) >>> 20);
        u.func = i[14:12]; u.asel = A_REG; u.bsel = B_IMM; u.fsel = (f3 == 5) && i[30];
        bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
      end
      7'b0110011: begin
        u.func = i[14:12]; u.fsel = i[30]; u.asel = A_REG; u.bsel = B_REG;
        if (f7 == 32)     bad = !(f3 == 0 || f3 == 5);
        else if (f7 == 1) begin bad = !en_m; u.muldiv = en_m; end
        else              bad = (f7 != 0);
      end
      7'b0001111: begin u.rd = '0; bad = (f3 != 0); end
      7'b1110011: begin
        if (f3 == 0) begin
          u.exc = 1'b1; u.rd = '0;
          if (i == 32'h00000073)      u.ecause = 4'd11;
          else if (i == 32'h00100073) u.ecause = 4'd3;
          else                        u.ecause = 4'd2;
        end else if (f3 == 4) begin
          bad = 1'b1;
        end else begin
          u.asel = (f3 >= 4) ? A_IMM : A_REG; u.wsel = W_CSR;
          if (f3 % 4 == 1) begin
            u.bsel = B_ZERO; u.func = F_OR; u.rcsr = (i[11:7] != 0); u.wcsr = 1'b1;
          end else begin
            u.bsel = B_CSR; u.rcsr = 1'b1; u.wcsr = (i[19:15] != 0);
            u.func = (f3 % 4 == 2) ? F_OR : F_ANDC; u.fsel = (f3 % 4 == 3);
          end
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      u.exc = 1'b1; u.ecause = 4'd2; u.rd = '0;
      u.load = 0; u.store = 0; u.branch = 0; u.jump = 0; u.wcsr = 0; u.rcsr = 0; u.muldiv = 0;
    end
    return u;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0] ops [11];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    i = $urandom;
    if ($urandom_range(0, 9) != 0) i[6:0] = ops[$urandom_range(0, 10)];
    if ((i[6:0] == 7'h33 || i[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
      i[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 : (($urandom_range(0, 1) == 0) ? 7'h20 : 7'h01);
    if (i[6:0] == 7'h73 && $urandom_range(0, 2) == 0)
      i = ($urandom_range(0, 1) == 0) ? 32'h00000073 : 32'h00100073;
    return i;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    in_valid   = v;
    instr      = ins;
    out_ready  = ordy;
    flush      = fl;
    pc_in      = $urandom & 32'hFFFFFFFC;
    next_pc_in = pc_in + 32'd4;
    rs1_data   = $urandom;
    rs2_data   = $urandom;
  endtask

  // Advance the reference queue by the handshake rules, then clock the DUTs.
  task automatic tick();
    int n;
    bit rdy;
    n   = q.size();
    rdy = (n < DEPTH) || out_ready;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (n > 0 && out_ready) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{instr, pc_in, next_pc_in, rs1_data, rs2_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (w_out[k].ov !== 1'b0 || w_out[k].ir !== 1'b1 || w_out[k].cnt !== 2'd0) begin
        errors++;
        $display("FAIL reset_flags[%0d] got ov=%b ir=%b cnt=%0d want 0 1 0", k, w_out[k].ov, w_out[k].ir, w_out[k].cnt);
      end
      checks++;
      if (w_out[k].u !== '0) begin
        errors++;
        $display("FAIL reset_payload[%0d] got %h want 0", k, w_out[k].u);
      end
    end
  endtask

  task automatic test_addi();
    drive(1'b1, 32'hFFB10093, 1'b1, 1'b0);
    tick();
    checks++;
    if (w_out[0].ov !== 1'b1 || w_out[0].u.imm !== 32'hFFFFFFFB || w_out[0].u.rd !== 5'd1 ||
        w_out[0].u.bsel !== B_IMM || w_out[0].u.rs1 !== 5'd2) begin
      errors++;
      $display("FAIL addi got ov=%b imm=%h rd=%0d bsel=%0d rs1=%0d want 1 fffffffb 1 %0d 2",
               w_out[0].ov, w_out[0].u.imm, w_out[0].u.rd, w_out[0].u.bsel, w_out[0].u.rs1, B_IMM);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checks++;
    if (w_out[0].cnt !== 2'd0 || w_out[0].ov !== 1'b0) begin
      errors++;
      $display("FAIL addi_drain got cnt=%0d ov=%b want 0 0", w_out[0].cnt, w_out[0].ov);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h00100293, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00200313, 1'b0, 1'b0); tick();
    checks++;
    if (w_out[0].ir !== 1'b0 || w_out[0].cnt !== 2'd2) begin
      errors++;
      $display("FAIL full got ir=%b cnt=%0d want 0 2", w_out[0].ir, w_out[0].cnt);
    end
    drive(1'b1, 32'h00300393, 1'b0, 1'b0); tick();
    checks++;
    if (w_out[0].cnt !== 2'd2 || w_out[0].u.rd !== 5'd5) begin
      errors++;
      $display("FAIL full_hold got cnt=%0d rd=%0d want 2 5", w_out[0].cnt, w_out[0].u.rd);
    end
    drive(1'b1, 32'h00300393, 1'b1, 1'b0);
    #1;
    checks++;
    if (w_out[0].ir !== 1'b1) begin
      errors++;
      $display("FAIL full_ready got ir=%b want 1", w_out[0].ir);
    end
    tick();
    checks++;
    if (w_out[0].cnt !== 2'd2 || w_out[0].u.rd !== 5'd6 || w_out[0].u.imm !== 32'd2) begin
      errors++;
      $display("FAIL push_pop got cnt=%0d rd=%0d imm=%h want 2 6 2", w_out[0].cnt, w_out[0].u.rd, w_out[0].u.imm);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].cnt !== 2'd1 || w_out[0].u.rd !== 5'd7) begin
      errors++;
      $display("FAIL order got cnt=%0d rd=%0d want 1 7", w_out[0].cnt, w_out[0].u.rd);
    end
    tick();
  endtask

  task automatic test_branch();
    drive(1'b1, 32'hFE000EE3, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].u.imm !== 32'hFFFFFFFC || w_out[0].u.branch !== 1'b1 || w_out[0].u.rd !== 5'd0 ||
        w_out[0].u.asel !== A_PC) begin
      errors++;
      $display("FAIL beq got imm=%h br=%b rd=%0d asel=%0d want fffffffc 1 0 %0d",
               w_out[0].u.imm, w_out[0].u.branch, w_out[0].u.rd, w_out[0].u.asel, A_PC);
    end
    drive(1'b1, 32'h0020E463, 1'b1, 1'b0); tick();
    checks++;
    if ({w_out[0].u.cless, w_out[0].u.csign, w_out[0].u.cneg} !== 3'b110 || w_out[0].u.imm !== 32'd8) begin
      errors++;
      $display("FAIL bltu got cmp=%b%b%b imm=%h want 110 8",
               w_out[0].u.cless, w_out[0].u.csign, w_out[0].u.cneg, w_out[0].u.imm);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h00100293, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00200313, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00300393, 1'b1, 1'b1); tick();
    checks++;
    if (w_out[0].cnt !== 2'd0 || w_out[0].ov !== 1'b0) begin
      errors++;
      $display("FAIL flush got cnt=%0d ov=%b want 0 0", w_out[0].cnt, w_out[0].ov);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0); tick();
    checks++;
    if (w_out[0].cnt !== 2'd0 || w_out[0].ov !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got cnt=%0d ov=%b want 0 0", w_out[0].cnt, w_out[0].ov);
    end
  endtask

  task automatic test_muldiv();
    drive(1'b1, 32'h022081B3, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].u.exc !== 1'b1 || w_out[0].u.ecause !== 4'd2 || w_out[0].u.rd !== 5'd0 || w_out[0].u.muldiv !== 1'b0) begin
      errors++;
      $display("FAIL mul_noM got exc=%b ec=%0d rd=%0d md=%b want 1 2 0 0",
               w_out[0].u.exc, w_out[0].u.ecause, w_out[0].u.rd, w_out[0].u.muldiv);
    end
    checks++;
    if (w_out[1].u.exc !== 1'b0 || w_out[1].u.muldiv !== 1'b1 || w_out[1].u.func !== 3'b000 || w_out[1].u.rd !== 5'd3) begin
      errors++;
      $display("FAIL mul_M got exc=%b md=%b func=%0d rd=%0d want 0 1 0 3",
               w_out[1].u.exc, w_out[1].u.muldiv, w_out[1].u.func, w_out[1].u.rd);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_system();
    drive(1'b1, 32'h00000073, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].u.exc !== 1'b1 || w_out[0].u.ecause !== 4'd11) begin
      errors++;
      $display("FAIL ecall got exc=%b ec=%0d want 1 11", w_out[0].u.exc, w_out[0].u.ecause);
    end
    drive(1'b1, 32'h00100073, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].u.exc !== 1'b1 || w_out[0].u.ecause !== 4'd3) begin
      errors++;
      $display("FAIL ebreak got exc=%b ec=%0d want 1 3", w_out[0].u.exc, w_out[0].u.ecause);
    end
    drive(1'b1, 32'h30002073, 1'b1, 1'b0); tick();
    checks++;
    if (w_out[0].u.rcsr !== 1'b1 || w_out[0].u.wcsr !== 1'b0 || w_out[0].u.csr !== 12'h300 || w_out[0].u.exc !== 1'b0) begin
      errors++;
      $display("FAIL csrrs got rd_csr=%b wr_csr=%b csr=%h exc=%b want 1 0 300 0",
               w_out[0].u.rcsr, w_out[0].u.wcsr, w_out[0].u.csr, w_out[0].u.exc);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h00100293, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h00200313, 1'b0, 1'b0); tick();
    reset = 1'b1;
    drive(1'b1, 32'h00300393, 1'b1, 1'b0); tick();
    reset = 1'b0;
    checks++;
    if (w_out[0].cnt !== 2'd0 || w_out[0].ov !== 1'b0 || w_out[0].u !== '0) begin
      errors++;
      $display("FAIL reset_mid got cnt=%0d ov=%b payload=%h want 0 0 0", w_out[0].cnt, w_out[0].ov, w_out[0].u);
    end
  endtask

  task automatic test_random();
    uop_t exp;
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (w_out[k].s1 !== instr[19:15] || w_out[k].s2 !== instr[24:20]) begin
          errors++;
          $display("FAIL rnd_sel[%0d] got %0d/%0d want %0d/%0d", k, w_out[k].s1, w_out[k].s2, instr[19:15], instr[24:20]);
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (w_out[k].ov !== (q.size() != 0) || w_out[k].cnt !== 2'(q.size()) ||
            w_out[k].ir !== ((q.size() < DEPTH) || out_ready)) begin
          errors++;
          $display("FAIL rnd_flow[%0d] got ov=%b cnt=%0d ir=%b want size=%0d ordy=%b",
                   k, w_out[k].ov, w_out[k].cnt, w_out[k].ir, q.size(), out_ready);
        end
        if (q.size() != 0) begin
          exp = ref_decode(q[0], k == 1);
          checks++;
          if (w_out[k].u !== exp) begin
            errors++;
            $display("FAIL rnd_uop[%0d] instr=%h got %h want %h", k, q[0].instr, w_out[k].u, exp);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_addi();
    test_back_to_back();
    test_branch();
    test_flush();
    test_muldiv();
    test_system();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the single-register decode stage. It decodes one RV32I instruction per cycle (optionally RV32M) and buffers decoded micro-ops in a DEPTH-entry FIFO.
- It replaces the global stall input with valid/ready handshakes on both sides.
- It sits between fetch and execute. It decouples fetch from back-pressure and provides a one-cycle pipeline flush for branches and traps.

Parameters:
- DEPTH, 2, number of micro-op entries; power of two, at least 1.
- ENABLE_M, 0, when 1, OP with funct7=0000001 is legal and marked mul_div.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction offered by fetch
- in_ready  out  1  queue can accept this cycle
- instr  in  32  instruction word
- pc_in  in  32  instruction PC
- next_pc_in  in  32  fall-through PC
- rs1_select  out  5  instr[19:15], combinational register-file read address
- rs2_select  out  5  instr[24:20], combinational register-file read address
- rs1_data  in  32  register-file read data, same cycle
- rs2_data  in  32  register-file read data, same cycle
- flush  in  1  discard all queued and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- pc_out, next_pc_out, data_rs1, data_rs2, data_imm  out  32 each  head payload
- rs1_addr, rs2_addr, rd_addr  out  5 each  head register addresses; rd_addr=0 means no write
- csr_addr  out  12  head instr[31:20]
- alu_func  out  3  head ALU function
- alu_func_sel  out  1  head ALU function select
- alu_a_select, alu_b_select, write_select  out  2 each  head operand/writeback selects
- load_store_size  out  2  head access size
- jump, branch, load, load_signed, store, read_csr, write_csr, mul_div, exception  out  1 each  head control flags
- cmp_less, cmp_sign, cmp_negate  out  1 each  head compare controls
- ecause  out  4  head exception cause
- count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Handshake and flow:
  - Push = in_valid && in_ready && !flush. Pop = out_valid && out_ready.
  - out_valid = (count != 0). in_ready = (count < DEPTH) || out_ready. A full queue therefore accepts a push in the same cycle as a pop.
  - Latency: an instruction accepted at edge N appears at the head with out_valid=1 after edge N; it is never combinationally bypassed.
  - Payload outputs are driven from the head entry. They are stable while out_valid=1 and out_ready=0.
- Data capture: rs1_data and rs2_data are sampled at the accepting edge. Stale data is resolved downstream by forwarding on rs1_addr/rs2_addr.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is updated +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
- flush: at the next edge count=0, pointers=0, out_valid=0. A concurrent push is dropped. flush has priority over push and pop.
- Reset: identical to flush, and additionally clears all storage.
  - After reset: out_valid=0, in_ready=1, count=0, every payload output reads 0.
  - A reset asserted mid-stream discards all queued entries.
- Immediates:
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): sign-extended J immediate.
  - I-type (1100111, 0000011, 0010011): sign-extended instr[31:20].
  - S-type (0100011): sign-extended {instr[31:25], instr[11:7]}.
  - B-type (1100011): sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - All other opcodes: 0.
- Decode per opcode. Flags not listed are 0; rd_addr=instr[11:7] unless stated.
  - LUI: OR, a=ZERO, b=IMM, write_select=ALU.
  - AUIPC: ADD, a=PC, b=IMM, write_select=ALU.
  - JAL: ADD, a=PC, b=IMM, write_select=NEXT_PC, branch=1, jump=1.
  - JALR: as JAL but a=REG. funct3 != 0 is illegal.
  - BRANCH: ADD, a=PC, b=IMM, branch=1, rd=0, cmp_less/sign/negate=instr[14]/[13]/[12]. funct3 010 and 011 are illegal.
  - LOAD: ADD, a=REG, b=IMM, write_select=LOAD, load=1, size=instr[13:12], load_signed=!instr[14]. Size 11, or instr[14] with size 10, is illegal.
  - STORE: ADD, a=REG, b=IMM, store=1, rd=0. Size 11 or instr[14]=1 is illegal.
  - OP-IMM: alu_func=funct3, a=REG, b=IMM. alu_func_sel=instr[30] only for funct3 101. For funct3 001, funct7 must be 0; for 101, funct7 must be 0 or 0100000; otherwise illegal.
  - OP: alu_func=funct3, alu_func_sel=instr[30], a=REG, b=REG.
    - funct7 0000000 is legal.
    - funct7 0100000 is legal only with funct3 000 or 101.
    - funct7 0000001 is legal only if ENABLE_M, and sets mul_div=1.
    - Anything else is illegal.
  - FENCE: rd=0, no operation. funct3 != 000 is illegal.
  - SYSTEM funct3 000: exception=1, rd=0. ecause=3 for EBREAK, 11 for ECALL, 2 if any of instr[31:21] or instr[19:7] are nonzero.
  - SYSTEM CSR ops (funct3 001/010/011, 101/110/111):
    - a=REG for 0xx, IMM for 1xx.
    - RW variants: b=ZERO, alu_func=OR, read_csr=(rd!=0), write_csr=1.
    - RS variants: b=CSR, alu_func=OR, read_csr=1, write_csr=(instr[19:15]!=0).
    - RC variants: b=CSR, alu_func=AND_CLR, alu_func_sel=1, read_csr=1, write_csr=(instr[19:15]!=0).
    - funct3 100 is illegal.
  - Illegal instruction: exception=1, ecause=2, rd=0, load/store/branch/write_csr=0. It is still queued in order.
  - Undefined opcode: treated as illegal.

Test Plan:
- Reset, then push ADDI x1,x2,-5 (0xFFB10093) with out_ready=1. Expect out_valid one cycle later, data_imm=0xFFFFFFFB, rd_addr=1, alu_b_select=IMM, count returns to 0.
- DEPTH=2, out_ready=0, push 3 instructions. Expect in_ready=0 after two accepts, count=2. Then out_ready=1 with in_valid=1 gives simultaneous push/pop, count stays 2, FIFO order preserved.
- BEQ with offset -4 (0xFE000EE3). Expect data_imm=0xFFFFFFFC, branch=1, rd_addr=0. BLTU gives cmp_less=1, cmp_sign=1, cmp_negate=0.
- Two queued entries plus push and flush in the same cycle. Next cycle count=0, out_valid=0, pushed instruction absent.
- MUL x3,x1,x2 (0x022081B3): with ENABLE_M=0 expect exception=1, ecause=2. With ENABLE_M=1 expect mul_div=1, alu_func=000.
- ECALL (0x00000073) gives ecause=11, EBREAK (0x00100073) gives ecause=3, CSRRS x0,mstatus,x0 gives read_csr=1 and write_csr=0.
